// File: rtl/ar_request_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : ar_request_fifo_if
// Brief    : AXI read-address channel bundle with master/slave views.
// Revision : 1.0
// ============================================================================
interface ar_request_fifo_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_TYPE = 2,
  parameter int BURST_LEN  = 8,
  parameter int BEAT_SIZE  = 3,
  parameter int ID         = 5
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [BURST_TYPE-1:0] ARBURST;
  logic [BURST_LEN-1:0]  ARLEN;
  logic [BEAT_SIZE-1:0]  ARSIZE;
  logic [ID-1:0]         ARID;
  logic                  ARVALID;
  logic                  ARREADY;

  modport master (output ARADDR, ARBURST, ARLEN, ARSIZE, ARID, ARVALID, input ARREADY);
  modport slave  (input ARADDR, ARBURST, ARLEN, ARSIZE, ARID, ARVALID, output ARREADY);
endinterface
`default_nettype wire

// File: rtl/ar_request_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ar_request_fifo
// Brief    : First-word-fall-through AXI AR request FIFO with status flags,
//            flush and AR protocol checking (flag-and-store / flag-and-drop).
// Revision : 1.0
// ============================================================================
module ar_request_fifo #(
  parameter int AR_FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int BURST_TYPE    = 2,
  parameter int BURST_LEN     = 8,
  parameter int BEAT_SIZE     = 3,
  parameter int ID            = 5,
  parameter int MAX_SIZE      = 3,
  parameter int AF_THRESH     = AR_FIFO_DEPTH - 2,
  parameter int AE_THRESH     = 1,
  parameter int CHECK_MODE    = 1
) (
  input  wire logic                               AR_fifo_clk,
  input  wire logic                               AR_fifo_rst,
  input  wire logic                               AR_fifo_flush,
  ar_request_fifo_if.slave                        s_ar,
  ar_request_fifo_if.master                       m_ar,
  output logic [$clog2(AR_FIFO_DEPTH+1)-1:0]      AR_fifo_count,
  output logic                                    AR_fifo_full,
  output logic                                    AR_fifo_empty,
  output logic                                    AR_fifo_almost_full,
  output logic                                    AR_fifo_almost_empty,
  output logic                                    AR_err_valid,
  output logic [2:0]                              AR_err_code,
  output logic [ADDR_WIDTH-1:0]                   AR_err_addr,
  output logic [ID-1:0]                           AR_err_id,
  output logic [7:0]                              AR_err_cnt
);
  localparam int c_PTR_W   = $clog2(AR_FIFO_DEPTH);
  localparam int c_CNT_W   = $clog2(AR_FIFO_DEPTH+1);
  localparam int c_ENTRY_W = ADDR_WIDTH + BURST_TYPE + BURST_LEN + BEAT_SIZE + ID;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(AR_FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AF_THRESH);
  localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AE_THRESH);

  logic [c_ENTRY_W-1:0] r_mem [AR_FIFO_DEPTH];
  logic [c_ENTRY_W-1:0] r_head;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_err_valid;
  logic [2:0]           r_err_code;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [ID-1:0]        r_err_id;
  logic [7:0]           r_err_cnt;

  logic                 w_full;
  logic                 w_s_ready;
  logic                 w_m_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err;
  logic                 w_store;
  logic [2:0]           w_err_code;
  logic [16:0]          w_bytes;
  logic [16:0]          w_end;
  logic [c_PTR_W-1:0]   w_rd_next;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic [c_ENTRY_W-1:0] w_s_entry;

  assign w_full    = (r_count == c_DEPTH);
  // Ready is forced low during reset so nothing can be accepted before the pointers are valid.
  assign w_s_ready = AR_fifo_rst && !w_full && !AR_fifo_flush;
  assign w_m_valid = (r_count != '0);
  assign w_push    = s_ar.ARVALID && w_s_ready;
  assign w_pop     = w_m_valid && m_ar.ARREADY;
  assign w_s_entry = {s_ar.ARADDR, s_ar.ARBURST, s_ar.ARLEN, s_ar.ARSIZE, s_ar.ARID};

  assign w_bytes = (17'(s_ar.ARLEN) + 17'd1) << s_ar.ARSIZE;
  assign w_end   = {5'b0, s_ar.ARADDR[11:0]} + w_bytes;

  always_comb begin
    w_err_code = 3'd0;
    if (CHECK_MODE != 0) begin
      if (s_ar.ARBURST == BURST_TYPE'(3))
        w_err_code = 3'd1;
      else if (s_ar.ARSIZE > BEAT_SIZE'(MAX_SIZE))
        w_err_code = 3'd2;
      else if ((s_ar.ARBURST == BURST_TYPE'(2)) &&
               !((s_ar.ARLEN == BURST_LEN'(1)) || (s_ar.ARLEN == BURST_LEN'(3)) ||
                 (s_ar.ARLEN == BURST_LEN'(7)) || (s_ar.ARLEN == BURST_LEN'(15))))
        w_err_code = 3'd3;
      else if ((s_ar.ARBURST == BURST_TYPE'(1)) && (w_end > 17'd4096))
        w_err_code = 3'd4;
    end
  end

  assign w_err      = w_push && (w_err_code != 3'd0);
  assign w_store    = w_push && !((CHECK_MODE == 2) && w_err);
  assign w_rd_next  = r_rd_ptr + c_PTR_W'(w_pop);
  assign w_cnt_next = r_count + c_CNT_W'(w_store) - c_CNT_W'(w_pop);

  always_ff @(posedge AR_fifo_clk) begin
    if (w_store)
      r_mem[r_wr_ptr] <= w_s_entry;
  end

  always_ff @(posedge AR_fifo_clk or negedge AR_fifo_rst) begin
    if (!AR_fifo_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (AR_fifo_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_next;
      // When the new head is the entry being written this cycle, bypass the memory.
      if (w_store && (w_rd_next == r_wr_ptr))
        r_head <= w_s_entry;
      else if (w_pop)
        r_head <= r_mem[w_rd_next];
    end
  end

  always_ff @(posedge AR_fifo_clk or negedge AR_fifo_rst) begin
    if (!AR_fifo_rst) begin
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_err_addr  <= '0;
      r_err_id    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_valid <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        r_err_addr <= s_ar.ARADDR;
        r_err_id   <= s_ar.ARID;
        if (r_err_cnt != 8'hFF)
          r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign s_ar.ARREADY = w_s_ready;
  assign m_ar.ARVALID = w_m_valid;
  assign {m_ar.ARADDR, m_ar.ARBURST, m_ar.ARLEN, m_ar.ARSIZE, m_ar.ARID} = r_head;

  assign AR_fifo_count        = r_count;
  assign AR_fifo_full         = w_full;
  assign AR_fifo_empty        = !w_m_valid;
  assign AR_fifo_almost_full  = (r_count >= c_AF);
  assign AR_fifo_almost_empty = (r_count <= c_AE);
  assign AR_err_valid         = r_err_valid;
  assign AR_err_code          = r_err_code;
  assign AR_err_addr          = r_err_addr;
  assign AR_err_id            = r_err_id;
  assign AR_err_cnt           = r_err_cnt;
endmodule
`default_nettype wire

// File: tb/tb_ar_request_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ar_request_fifo
// Brief    : Directed bench driving a flag-and-store and a flag-and-drop FIFO.
// Revision : 1.0
// ============================================================================
module tb_ar_request_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] r_addr  = '0;
  logic [1:0]  r_burst = '0;
  logic [7:0]  r_len   = '0;
  logic [2:0]  r_size  = '0;
  logic [4:0]  r_id    = '0;
  logic        r_valid = 1'b0;
  logic        r_mready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  ar_request_fifo_if s1();
  ar_request_fifo_if m1();
  ar_request_fifo_if s2();
  ar_request_fifo_if m2();

  assign s1.ARADDR = r_addr;  assign s2.ARADDR = r_addr;
  assign s1.ARBURST = r_burst; assign s2.ARBURST = r_burst;
  assign s1.ARLEN = r_len;    assign s2.ARLEN = r_len;
  assign s1.ARSIZE = r_size;  assign s2.ARSIZE = r_size;
  assign s1.ARID = r_id;      assign s2.ARID = r_id;
  assign s1.ARVALID = r_valid; assign s2.ARVALID = r_valid;
  assign m1.ARREADY = r_mready; assign m2.ARREADY = r_mready;

  logic [4:0]  cnt1, cnt2;
  logic        full1, empty1, af1, ae1, ev1;
  logic        full2, empty2, af2, ae2, ev2;
  logic [2:0]  ec1, ec2;
  logic [31:0] ea1, ea2;
  logic [4:0]  eid1, eid2;
  logic [7:0]  ecnt1, ecnt2;

  ar_request_fifo #(.CHECK_MODE(1)) u_dut1 (
    .AR_fifo_clk(clk), .AR_fifo_rst(rst_n), .AR_fifo_flush(flush),
    .s_ar(s1.slave), .m_ar(m1.master),
    .AR_fifo_count(cnt1), .AR_fifo_full(full1), .AR_fifo_empty(empty1),
    .AR_fifo_almost_full(af1), .AR_fifo_almost_empty(ae1),
    .AR_err_valid(ev1), .AR_err_code(ec1), .AR_err_addr(ea1),
    .AR_err_id(eid1), .AR_err_cnt(ecnt1));

  ar_request_fifo #(.CHECK_MODE(2)) u_dut2 (
    .AR_fifo_clk(clk), .AR_fifo_rst(rst_n), .AR_fifo_flush(flush),
    .s_ar(s2.slave), .m_ar(m2.master),
    .AR_fifo_count(cnt2), .AR_fifo_full(full2), .AR_fifo_empty(empty2),
    .AR_fifo_almost_full(af2), .AR_fifo_almost_empty(ae2),
    .AR_err_valid(ev2), .AR_err_code(ec2), .AR_err_addr(ea2),
    .AR_err_id(eid2), .AR_err_cnt(ecnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l,
                         input logic [2:0] s, input logic [4:0] id);
    r_addr = a; r_burst = b; r_len = l; r_size = s; r_id = id;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (cnt1 !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
    n_checks++; if ({empty1, ae1, full1, af1} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got=%b exp=1100", {empty1, ae1, full1, af1}); end
    n_checks++; if (m1.ARVALID !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b exp=0", m1.ARVALID); end
    n_checks++; if (s1.ARREADY !== 1'b0) begin n_fail++; $display("FAIL reset_sready got=%b exp=0", s1.ARREADY); end
    n_checks++; if ({ev1, ec1, ecnt1, m1.ARADDR} !== '0) begin n_fail++; $display("FAIL reset_regs got err_cnt=%0d m_addr=%h exp=0", ecnt1, m1.ARADDR); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (s1.ARREADY !== 1'b1) begin n_fail++; $display("FAIL reset_release_sready got=%b exp=1", s1.ARREADY); end
  endtask

  task automatic test_fill();
    r_mready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_req(32'h1000 + 32'(16*i), 2'd1, 8'd0, 3'd2, 5'(i));
      r_valid = 1'b1;
      #1;
      n_checks++; if (s1.ARREADY !== 1'b1) begin n_fail++; $display("FAIL fill_sready i=%0d got=%b exp=1", i, s1.ARREADY); end
      tick();
      n_checks++; if (cnt1 !== 5'(i+1)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, cnt1, i+1); end
      n_checks++; if (af1 !== ((i+1) >= 14)) begin n_fail++; $display("FAIL fill_af i=%0d got=%b", i, af1); end
      n_checks++; if (full1 !== ((i+1) == 16)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b", i, full1); end
      if (i == 0) begin
        n_checks++; if ({m1.ARVALID, m1.ARADDR} !== {1'b1, 32'h1000}) begin n_fail++; $display("FAIL fill_first_head got=%b/%h exp=1/1000", m1.ARVALID, m1.ARADDR); end
      end
    end
    set_req(32'h1100, 2'd1, 8'd0, 3'd2, 5'd16);
    #1;
    n_checks++; if (s1.ARREADY !== 1'b0) begin n_fail++; $display("FAIL full_sready got=%b exp=0", s1.ARREADY); end
    tick();
    n_checks++; if (cnt1 !== 5'd16) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=16", cnt1); end
    r_mready = 1'b1;
    tick();
    r_mready = 1'b0;
    #1;
    n_checks++; if (cnt1 !== 5'd15) begin n_fail++; $display("FAIL full_pop_count got=%0d exp=15", cnt1); end
    n_checks++; if (s1.ARREADY !== 1'b1) begin n_fail++; $display("FAIL full_pop_sready got=%b exp=1", s1.ARREADY); end
    n_checks++; if (m1.ARADDR !== 32'h1010) begin n_fail++; $display("FAIL full_pop_head got=%h exp=1010", m1.ARADDR); end
    tick();
    r_valid = 1'b0;
    n_checks++; if (cnt1 !== 5'd16) begin n_fail++; $display("FAIL full_17th_count got=%0d exp=16", cnt1); end
    r_mready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      logic [31:0] exp_a;
      exp_a = (j < 15) ? 32'h1010 + 32'(16*j) : 32'h1100;
      n_checks++; if (m1.ARADDR !== exp_a) begin n_fail++; $display("FAIL drain_order j=%0d got=%h exp=%h", j, m1.ARADDR, exp_a); end
      tick();
    end
    n_checks++; if ({cnt1, empty1, m1.ARVALID} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL drain_empty got cnt=%0d empty=%b valid=%b", cnt1, empty1, m1.ARVALID); end
  endtask

  task automatic test_back_to_back();
    r_mready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_req(32'h2000 + 32'(4*i), 2'd1, 8'd0, 3'd2, 5'(i));
      r_valid = 1'b1;
      tick();
      n_checks++; if ({m1.ARVALID, m1.ARADDR} !== {1'b1, 32'h2000 + 32'(4*i)}) begin n_fail++; $display("FAIL stream_head i=%0d got=%b/%h", i, m1.ARVALID, m1.ARADDR); end
      n_checks++; if (cnt1 !== 5'd1) begin n_fail++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, cnt1); end
    end
    r_valid = 1'b0;
    tick();
    n_checks++; if (cnt1 !== 5'd0) begin n_fail++; $display("FAIL stream_end_count got=%0d exp=0", cnt1); end
  endtask

  task automatic test_protocol_checks();
    r_mready = 1'b0;
    r_valid = 1'b1;
    set_req(32'h0FF0, 2'd1, 8'd3, 3'd3, 5'd7);
    tick();
    n_checks++; if ({ev2, ec2, ea2, eid2} !== {1'b1, 3'd4, 32'h0FF0, 5'd7}) begin n_fail++; $display("FAIL drop_4k_err got v=%b c=%0d a=%h id=%0d exp 1/4/0ff0/7", ev2, ec2, ea2, eid2); end
    n_checks++; if ({cnt2, m2.ARVALID} !== {5'd0, 1'b0}) begin n_fail++; $display("FAIL drop_4k_count got=%0d valid=%b exp=0/0", cnt2, m2.ARVALID); end
    n_checks++; if ({ev1, ec1, cnt1, m1.ARVALID, m1.ARADDR} !== {1'b1, 3'd4, 5'd1, 1'b1, 32'h0FF0}) begin n_fail++; $display("FAIL store_4k got v=%b c=%0d cnt=%0d addr=%h exp 1/4/1/0ff0", ev1, ec1, cnt1, m1.ARADDR); end
    set_req(32'h0040, 2'd2, 8'd2, 3'd2, 5'd1);
    tick();
    n_checks++; if ({ec2, ecnt2, cnt2} !== {3'd3, 8'd2, 5'd0}) begin n_fail++; $display("FAIL drop_wrap got c=%0d n=%0d cnt=%0d exp 3/2/0", ec2, ecnt2, cnt2); end
    set_req(32'h0080, 2'd3, 8'd0, 3'd2, 5'd2);
    tick();
    n_checks++; if ({ec2, ecnt2} !== {3'd1, 8'd3}) begin n_fail++; $display("FAIL drop_rsvd got c=%0d n=%0d exp 1/3", ec2, ecnt2); end
    set_req(32'h0100, 2'd2, 8'd3, 3'd4, 5'd3);
    tick();
    n_checks++; if ({ec2, ecnt2} !== {3'd2, 8'd4}) begin n_fail++; $display("FAIL drop_size got c=%0d n=%0d exp 2/4", ec2, ecnt2); end
    set_req(32'h0FE0, 2'd1, 8'd3, 3'd3, 5'd4);
    tick();
    n_checks++; if ({ev2, ec2, cnt2, m2.ARADDR} !== {1'b0, 3'd2, 5'd1, 32'h0FE0}) begin n_fail++; $display("FAIL edge_4k_legal got v=%b c=%0d cnt=%0d addr=%h exp 0/2/1/0fe0", ev2, ec2, cnt2, m2.ARADDR); end
    set_req(32'h0FF0, 2'd0, 8'd3, 3'd3, 5'd5);
    tick();
    r_valid = 1'b0;
    n_checks++; if ({ev2, cnt2} !== {1'b0, 5'd2}) begin n_fail++; $display("FAIL fixed_legal got v=%b cnt=%0d exp 0/2", ev2, cnt2); end
    tick();
    n_checks++; if ({cnt1, ecnt1, ea1} !== {5'd6, 8'd4, 32'h0100}) begin n_fail++; $display("FAIL store_totals got cnt=%0d n=%0d a=%h exp 6/4/0100", cnt1, ecnt1, ea1); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    r_mready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(32'h4000 + 32'(16*i), 2'd1, 8'd0, 3'd2, 5'(i));
      r_valid = 1'b1;
      tick();
    end
    n_checks++; if (cnt1 !== 5'd5) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=5", cnt1); end
    set_req(32'h5000, 2'd1, 8'd0, 3'd2, 5'd9);
    flush = 1'b1;
    #1;
    n_checks++; if (s1.ARREADY !== 1'b0) begin n_fail++; $display("FAIL flush_sready got=%b exp=0", s1.ARREADY); end
    tick();
    flush = 1'b0;
    r_valid = 1'b0;
    n_checks++; if ({cnt1, empty1, m1.ARVALID} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush_state got cnt=%0d empty=%b valid=%b exp 0/1/0", cnt1, empty1, m1.ARVALID); end
    n_checks++; if ({ecnt1, ec1, ea1} !== {8'd4, 3'd2, 32'h0100}) begin n_fail++; $display("FAIL flush_err_kept got n=%0d c=%0d a=%h exp 4/2/0100", ecnt1, ec1, ea1); end
  endtask

  task automatic test_async_reset();
    r_mready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_req(32'h6000 + 32'(16*i), 2'd1, 8'd0, 3'd2, 5'(i));
      r_valid = 1'b1;
      tick();
    end
    n_checks++; if (cnt1 !== 5'd7) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=7", cnt1); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({cnt1, m1.ARVALID, s1.ARREADY} !== {5'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL areset_drop got cnt=%0d valid=%b ready=%b exp 0/0/0", cnt1, m1.ARVALID, s1.ARREADY); end
    n_checks++; if ({ecnt1, ec1} !== {8'd0, 3'd0}) begin n_fail++; $display("FAIL areset_err got n=%0d c=%0d exp 0/0", ecnt1, ec1); end
    #1;
    rst_n = 1'b1;
    set_req(32'h3000, 2'd1, 8'd0, 3'd2, 5'd3);
    r_valid = 1'b1;
    #1;
    n_checks++; if ({cnt1, s1.ARREADY} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL areset_release got cnt=%0d ready=%b exp 0/1", cnt1, s1.ARREADY); end
    tick();
    r_valid = 1'b0;
    n_checks++; if ({m1.ARVALID, m1.ARADDR, cnt1} !== {1'b1, 32'h3000, 5'd1}) begin n_fail++; $display("FAIL areset_first_push got v=%b a=%h cnt=%0d exp 1/3000/1", m1.ARVALID, m1.ARADDR, cnt1); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_protocol_checks();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
